// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the async FIFO and presents words as a valid/ready stream via a
// 2-entry (main + skid) buffer. Optional delivered-word counter enabled by RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready
`ifdef RD_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_count
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] main_q, main_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             pop, acc;

  // Pop decision looks only at occupancy, so m_ready never reaches rinc combinationally.
  assign rinc    = rrst_n && !rempty && (state_q != StTwo);
  assign pop     = rinc;
  assign m_valid = (state_q != StEmpty);
  assign m_data  = main_q;
  assign acc     = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (pop) begin
          main_d  = rdata;
          state_d = StOne;
        end
      end
      StOne: begin
        if (pop && acc) begin
          main_d = rdata;
        end else if (pop) begin
          skid_d  = rdata;
          state_d = StTwo;
        end else if (acc) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (acc) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef RD_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (acc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_count = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: cycle tables, hand sequences for reset corners, and a random
// bubble run checked against an occupancy/queue model.
module tb_fifo_rd_stream;
  localparam int unsigned DSIZE = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    bit             rdy;
    bit             rinc;
    bit             valid;
    logic [7:0]     data;
  } vec_t;

  logic             rclk;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;
`ifdef RD_STREAM_CNT_EN
  logic [CNT_W-1:0] rd_count;
`endif

  fifo_rd_stream #(
    .DSIZE(DSIZE),
    .CNT_W(CNT_W)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
`ifdef RD_STREAM_CNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  int checks = 0;
  int errors = 0;

  // Environment FIFO contents and the reference model of the stage.
  logic [7:0] fifo[$];
  logic [7:0] wr_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         occ = 0;
  int         cnt = 0;
  bit         force_empty = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       s_rinc, s_valid;
  logic [7:0] s_data;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic drive_fifo();
    rempty = force_empty || (fifo.size() == 0);
    rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  // Called between edges: asserts reset, checks immediate effect, releases after next posedge.
  task automatic do_reset();
    rrst_n = 1'b0;
    #1;
    chk("rst.rinc", rinc, 0);
    chk("rst.m_valid", m_valid, 0);
    chk("rst.m_data", m_data, 0);
`ifdef RD_STREAM_CNT_EN
    chk("rst.rd_count", rd_count, 0);
`endif
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    occ        = 0;
    cnt        = 0;
    prev_stall = 1'b0;
  endtask

  task automatic start(int n, logic [7:0] base);
    fifo.delete();
    wr_q.delete();
    for (int i = 0; i < n; i++) begin
      fifo.push_back(base + 8'(i));
      wr_q.push_back(base + 8'(i));
    end
    force_empty = 1'b0;
    drive_fifo();
    do_reset();
  endtask

  // One clock: check outputs mid-cycle against the model, then advance model and FIFO.
  task automatic cycle();
    logic pop, acc;
    drive_fifo();
    @(negedge rclk);
    s_rinc  = rinc;
    s_valid = m_valid;
    s_data  = m_data;
    pop     = rinc && !rempty;
    acc     = m_valid && m_ready;
    chk("m_valid", m_valid, occ != 0);
    chk("rinc", rinc, !rempty && (occ < 2));
    if (m_valid && exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
    if (prev_stall) chk("stall_hold", m_data, prev_data);
`ifdef RD_STREAM_CNT_EN
    chk("rd_count", rd_count, cnt % (1 << CNT_W));
`endif
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    @(posedge rclk);
    #1;
    if (pop) begin
      exp_q.push_back(fifo.pop_front());
      occ++;
    end
    if (acc) begin
      got_q.push_back(s_data);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      occ--;
      cnt++;
    end
  endtask

  task automatic run_table(string tag, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      m_ready = tbl[i].rdy;
      cycle();
      chk($sformatf("%s[%0d].rinc", tag, i), s_rinc, tbl[i].rinc);
      chk($sformatf("%s[%0d].valid", tag, i), s_valid, tbl[i].valid);
      chk($sformatf("%s[%0d].data", tag, i), s_data, tbl[i].data);
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    force_empty = 1'b0;
    m_ready     = 1'b1;
    while ((fifo.size() != 0 || occ != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", n < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t stream_t[$];
    vec_t bp_t[$];
    // {m_ready, rinc, m_valid, m_data}
    stream_t.push_back('{1'b1, 1'b1, 1'b0, 8'h00});
    stream_t.push_back('{1'b1, 1'b1, 1'b1, 8'h11});
    stream_t.push_back('{1'b1, 1'b1, 1'b1, 8'h22});
    stream_t.push_back('{1'b1, 1'b0, 1'b1, 8'h33});
    stream_t.push_back('{1'b1, 1'b0, 1'b0, 8'h33});
    bp_t.push_back('{1'b0, 1'b1, 1'b0, 8'h00});
    bp_t.push_back('{1'b0, 1'b1, 1'b1, 8'hA0});
    bp_t.push_back('{1'b0, 1'b0, 1'b1, 8'hA0});
    bp_t.push_back('{1'b0, 1'b0, 1'b1, 8'hA0});
    bp_t.push_back('{1'b1, 1'b0, 1'b1, 8'hA0});
    bp_t.push_back('{1'b1, 1'b1, 1'b1, 8'hA1});
    bp_t.push_back('{1'b1, 1'b1, 1'b1, 8'hA2});
    bp_t.push_back('{1'b1, 1'b1, 1'b1, 8'hA3});
    bp_t.push_back('{1'b1, 1'b0, 1'b1, 8'hA4});
    bp_t.push_back('{1'b1, 1'b0, 1'b0, 8'hA4});

    rrst_n  = 1'b1;
    m_ready = 1'b0;
    rempty  = 1'b1;
    rdata   = '0;
    #2;

    // Streaming 11,22,33 at full rate.
    fifo.delete();
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    fifo.push_back(8'h33);
    drive_fifo();
    do_reset();
    run_table("stream", stream_t);

    // Backpressure with 5 words queued.
    start(5, 8'hA0);
    run_table("bp", bp_t);
    chk("bp.count", got_q.size(), 5);

    // Mid-operation reset while both buffer entries are full.
    start(6, 8'h60);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("mid.occ_before", occ, 2);
    do_reset();
    drain(30);
    chk("mid.count", got_q.size(), 4);
    if (got_q.size() != 0) chk("mid.first", got_q[0], 8'h62);

    // Random bubbles: rempty toggles each cycle, random ready, random writes.
    start(0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] w;
        w = 8'($urandom);
        fifo.push_back(w);
        wr_q.push_back(w);
      end
      force_empty = ~force_empty;
      m_ready     = 1'($urandom_range(0, 1));
      cycle();
    end
    drain(400);
    chk("rand.count", got_q.size(), wr_q.size());
    begin
      int bad = 0;
      for (int i = 0; i < got_q.size() && i < wr_q.size(); i++) begin
        if (got_q[i] !== wr_q[i]) bad++;
      end
      chk("rand.order", bad, 0);
    end

`ifdef RD_STREAM_CNT_EN
    // Counter wraps modulo 16: 17 accepts leave it at 1.
    start(20, 8'h40);
    m_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < 17; i++) cycle();
    chk("cnt.accepts", got_q.size(), 17);
    chk("cnt.rd_count17", rd_count, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
